// File: rtl/simd_pkg.sv
// -----------------------------------------------------------------------------
// simd_pkg
// Shared definitions for the SIMD execution pipeline:
//   - default geometry constants (lanes, lane width, depth, tag width)
//   - ALU operation encoding (matches the legacy ALUControl field)
//   - stage record layout for the default geometry
//   - scoreboard helper for the "scalar register 0 is never busy" rule
// -----------------------------------------------------------------------------
package simd_pkg;

    localparam int DEF_LANES  = 4;
    localparam int DEF_LANE_W = 32;
    localparam int DEF_DEPTH  = 3;
    localparam int DEF_RD_W   = 5;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_SLL  = 3'b101,
        ALU_ROTW = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_e;

    // Stage record for the default geometry; the pipeline declares an
    // equivalent record sized by its own parameters.
    typedef struct packed {
        logic                               valid;
        logic                               vec;
        logic [DEF_RD_W-1:0]                rd;
        logic [DEF_LANES*DEF_LANE_W-1:0]    result;
    } simd_stage_t;

    // Scalar register 0 is hard-wired, so a query for it never reports busy.
    function automatic logic tag_exempt(input logic q_vec, input logic tag_is_zero);
        return (!q_vec) && tag_is_zero;
    endfunction

endpackage

// File: rtl/simd_lane_pipe_if.sv
// -----------------------------------------------------------------------------
// simd_lane_pipe_if
// Bundle of every non-clock signal of simd_lane_pipe.
//   master : the surrounding core (ID/EX side, MEM side, hazard unit)
//   slave  : the pipeline itself
// Signals:
//   in_valid/in_ready, in_op, in_vec, in_a, in_b, in_rd : issue side
//   flush                                               : kill in-flight ops
//   out_valid/out_ready, out_result, out_rd, out_vec    : result side
//   q_vec, q_rs1, q_rs2 -> rs1_busy, rs2_busy           : scoreboard query
//   cnt_retired, cnt_stall                              : statistics
// -----------------------------------------------------------------------------
interface simd_lane_pipe_if
    import simd_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int RD_W   = DEF_RD_W
) ();

    logic                       in_valid;
    logic                       in_ready;
    logic [2:0]                 in_op;
    logic                       in_vec;
    logic [LANES*LANE_W-1:0]    in_a;
    logic [LANES*LANE_W-1:0]    in_b;
    logic [RD_W-1:0]            in_rd;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*LANE_W-1:0]    out_result;
    logic [RD_W-1:0]            out_rd;
    logic                       out_vec;
    logic                       q_vec;
    logic [RD_W-1:0]            q_rs1;
    logic [RD_W-1:0]            q_rs2;
    logic                       rs1_busy;
    logic                       rs2_busy;
    logic [31:0]                cnt_retired;
    logic [31:0]                cnt_stall;

    modport master (
        output in_valid, in_op, in_vec, in_a, in_b, in_rd, flush, out_ready,
               q_vec, q_rs1, q_rs2,
        input  in_ready, out_valid, out_result, out_rd, out_vec,
               rs1_busy, rs2_busy, cnt_retired, cnt_stall
    );

    modport slave (
        input  in_valid, in_op, in_vec, in_a, in_b, in_rd, flush, out_ready,
               q_vec, q_rs1, q_rs2,
        output in_ready, out_valid, out_result, out_rd, out_vec,
               rs1_busy, rs2_busy, cnt_retired, cnt_stall
    );

endinterface

// File: rtl/simd_lane_alu.sv
// -----------------------------------------------------------------------------
// simd_lane_alu
// One lane of the combinational SIMD ALU.
// Ports:
//   i_op : operation (simd_pkg::alu_op_e encoding)
//   i_a  : operand A
//   i_b  : operand B (shift amount for SLL, ignored for ROTW)
//   o_y  : result, modulo 2^LANE_W
// -----------------------------------------------------------------------------
module simd_lane_alu
    import simd_pkg::*;
#(
    parameter int LANE_W = DEF_LANE_W
) (
    input  logic [2:0]          i_op,
    input  logic [LANE_W-1:0]   i_a,
    input  logic [LANE_W-1:0]   i_b,
    output logic [LANE_W-1:0]   o_y
);

    // Only the low log2(LANE_W) bits of B select the shift distance.
    localparam int SH_W = $clog2(LANE_W);

    logic [LANE_W-1:0] w_y;

    // Lane operation select.
    always_comb begin
        w_y = '0;
        case (alu_op_e'(i_op))
            ALU_ADD:  w_y = i_a + i_b;
            ALU_SUB:  w_y = i_a - i_b;
            ALU_XOR:  w_y = i_a ^ i_b;
            ALU_AND:  w_y = i_a & i_b;
            ALU_OR:   w_y = i_a | i_b;
            ALU_SLL:  w_y = i_a << i_b[SH_W-1:0];
            ALU_ROTW: w_y = {i_a[LANE_W-9:0], i_a[LANE_W-1:LANE_W-8]};
            ALU_PASS: w_y = i_b;
            default:  w_y = i_b;
        endcase
    end

    assign o_y = w_y;

endmodule

// File: rtl/simd_lane_pipe.sv
// -----------------------------------------------------------------------------
// simd_lane_pipe
// LANES-wide SIMD execution pipeline between ID/EX and MEM.
// Ops are computed combinationally at the input, then carried through DEPTH
// register stages together with their destination tag and vector flag.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : simd_lane_pipe_if.slave (issue, result, flush, scoreboard
//              query and statistics counters)
// -----------------------------------------------------------------------------
module simd_lane_pipe
    import simd_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RD_W   = DEF_RD_W
) (
    input  logic            clk,
    input  logic            rst,
    simd_lane_pipe_if.slave bus
);

    localparam int DATA_W = LANES * LANE_W;

    // Same layout as simd_pkg::simd_stage_t, sized by this instance.
    typedef struct packed {
        logic               valid;
        logic               vec;
        logic [RD_W-1:0]    rd;
        logic [DATA_W-1:0]  result;
    } stage_t;

    stage_t [DEPTH-1:0] r_stg;
    stage_t             w_new;
    logic [DATA_W-1:0]  w_lane_res;
    logic               w_adv;
    logic               w_accept;
    logic               w_rs1_busy;
    logic               w_rs2_busy;
    logic [31:0]        r_cnt_retired;
    logic [31:0]        r_cnt_stall;

    // ---------------------------------------------------------------- compute
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LANE_W-1:0] w_y;

        simd_lane_alu #(.LANE_W(LANE_W)) u_alu (
            .i_op (bus.in_op),
            .i_a  (bus.in_a[l*LANE_W +: LANE_W]),
            .i_b  (bus.in_b[l*LANE_W +: LANE_W]),
            .o_y  (w_y)
        );

        // Scalar ops only produce lane 0; upper lanes are zeroed.
        if (l == 0) begin : g_l0
            assign w_lane_res[l*LANE_W +: LANE_W] = w_y;
        end else begin : g_ln
            assign w_lane_res[l*LANE_W +: LANE_W] = bus.in_vec ? w_y : '0;
        end
    end

    // --------------------------------------------------------------- control
    // The whole pipe moves together; a full last stage blocks everything.
    assign w_adv    = (!r_stg[DEPTH-1].valid) || bus.out_ready;
    assign w_accept = bus.in_valid && w_adv && (!bus.flush);

    // Record entering stage 0 (a bubble when nothing is accepted).
    always_comb begin
        w_new.valid  = w_accept;
        w_new.vec    = bus.in_vec;
        w_new.rd     = bus.in_rd;
        w_new.result = w_lane_res;
    end

    // Stage registers: kill on flush, shift on advance, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stg <= '0;
        end else if (bus.flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stg[k].valid <= 1'b0;
            end
        end else if (w_adv) begin
            r_stg[0] <= w_new;
            for (int k = 1; k < DEPTH; k++) begin
                r_stg[k] <= r_stg[k-1];
            end
        end else begin
            r_stg <= r_stg;
        end
    end

    // ------------------------------------------------------------ scoreboard
    // Pending-write lookup over every valid stage; the op being offered at the
    // input is deliberately not part of the search.
    always_comb begin
        w_rs1_busy = 1'b0;
        w_rs2_busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_stg[k].valid && (r_stg[k].vec == bus.q_vec)) begin
                if ((r_stg[k].rd == bus.q_rs1) &&
                    !tag_exempt(bus.q_vec, bus.q_rs1 == '0)) begin
                    w_rs1_busy = 1'b1;
                end else begin
                    w_rs1_busy = w_rs1_busy;
                end
                if ((r_stg[k].rd == bus.q_rs2) &&
                    !tag_exempt(bus.q_vec, bus.q_rs2 == '0)) begin
                    w_rs2_busy = 1'b1;
                end else begin
                    w_rs2_busy = w_rs2_busy;
                end
            end else begin
                w_rs1_busy = w_rs1_busy;
                w_rs2_busy = w_rs2_busy;
            end
        end
    end

    // -------------------------------------------------------------- counters
    // Retire/stall statistics; these survive flush and wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_retired <= 32'd0;
            r_cnt_stall   <= 32'd0;
        end else begin
            if (r_stg[DEPTH-1].valid && bus.out_ready) begin
                r_cnt_retired <= r_cnt_retired + 32'd1;
            end else begin
                r_cnt_retired <= r_cnt_retired;
            end
            if (r_stg[DEPTH-1].valid && !bus.out_ready) begin
                r_cnt_stall <= r_cnt_stall + 32'd1;
            end else begin
                r_cnt_stall <= r_cnt_stall;
            end
        end
    end

    // --------------------------------------------------------------- outputs
    assign bus.in_ready    = w_adv && (!bus.flush);
    assign bus.out_valid   = r_stg[DEPTH-1].valid;
    assign bus.out_result  = r_stg[DEPTH-1].result;
    assign bus.out_rd      = r_stg[DEPTH-1].rd;
    assign bus.out_vec     = r_stg[DEPTH-1].vec;
    assign bus.rs1_busy    = w_rs1_busy;
    assign bus.rs2_busy    = w_rs2_busy;
    assign bus.cnt_retired = r_cnt_retired;
    assign bus.cnt_stall   = r_cnt_stall;

endmodule

// File: tb/tb_simd_lane_pipe.sv
// -----------------------------------------------------------------------------
// tb_simd_lane_pipe
// Self-checking bench for simd_lane_pipe (LANES=4, LANE_W=32, DEPTH=3).
// Inputs are driven on the falling edge and outputs sampled 1 ns later; the
// DUT registers on the rising edge. Expected results come from a lane-level
// arithmetic model and an in-order queue of in-flight ops.
// -----------------------------------------------------------------------------
module tb_simd_lane_pipe;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int DEPTH  = 3;
    localparam int RD_W   = 5;
    localparam int DW     = LANES * LANE_W;

    typedef struct {
        logic [DW-1:0]   res;
        logic [RD_W-1:0] rd;
        logic            vec;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    simd_lane_pipe_if #(.LANES(LANES), .LANE_W(LANE_W), .RD_W(RD_W)) bus ();

    simd_lane_pipe #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .RD_W(RD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: per-lane arithmetic straight from the op table.
    function automatic logic [DW-1:0] ref_exec(input logic [2:0] op, input logic vec,
                                               input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic [31:0]   x;
        logic [31:0]   y;
        logic [31:0]   z;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            x = a[l*32 +: 32];
            y = b[l*32 +: 32];
            case (op)
                3'd0:    z = x + y;
                3'd1:    z = x - y;
                3'd2:    z = x ^ y;
                3'd3:    z = x & y;
                3'd4:    z = x | y;
                3'd5:    z = x << (y % 32);
                3'd6:    z = (x << 8) | (x >> 24);
                default: z = y;
            endcase
            if (vec || l == 0) r[l*32 +: 32] = z;
        end
        return r;
    endfunction

    // Is tag busy according to the bench's list of in-flight ops?
    function automatic logic model_busy(input logic qv, input logic [RD_W-1:0] tag);
        logic b;
        b = 1'b0;
        if (qv || tag != 5'd0) begin
            foreach (exp_q[i]) begin
                if (exp_q[i].vec == qv && exp_q[i].rd == tag) b = 1'b1;
            end
        end
        return b;
    endfunction

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_vec    = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_rd     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.q_vec     = 1'b0;
        bus.q_rs1     = '0;
        bus.q_rs2     = '0;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic vec, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [RD_W-1:0] rd);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_vec   = vec;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_rd    = rd;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_result !== '0 || bus.out_rd !== '0 || bus.out_vec !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b res=%h rd=%h vec=%b, expected all zero",
                     bus.out_valid, bus.out_result, bus.out_rd, bus.out_vec);
        end
        checks++;
        if (bus.cnt_retired !== 32'd0 || bus.cnt_stall !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d, expected 0/0", bus.cnt_retired, bus.cnt_stall);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
        end
    endtask

    task automatic test_add_vec();
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] want;
        apply_reset();
        a    = {32'hFFFF_FFFF, 32'd3, 32'd2, 32'd1};
        b    = {32'd1, 32'd1, 32'd1, 32'd1};
        want = {32'd0, 32'd4, 32'd3, 32'd2};
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive_op(3'd0, 1'b1, a, b, 5'd7);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_accept: in_ready got %b, expected 1", bus.in_ready);
        end
        for (int c = 1; c <= DEPTH; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            checks++;
            if (bus.out_valid !== (c == DEPTH)) begin
                errors++;
                $display("FAIL add_latency: cycle %0d out_valid got %b, expected %b", c, bus.out_valid, c == DEPTH);
            end
        end
        checks++;
        if (bus.out_result !== want || bus.out_result !== ref_exec(3'd0, 1'b1, a, b)) begin
            errors++;
            $display("FAIL add_result: got %h, expected %h", bus.out_result, want);
        end
        checks++;
        if (bus.out_rd !== 5'd7 || bus.out_vec !== 1'b1) begin
            errors++;
            $display("FAIL add_tag: got rd=%0d vec=%b, expected rd=7 vec=1", bus.out_rd, bus.out_vec);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.cnt_retired !== 32'd1) begin
            errors++;
            $display("FAIL add_retire: got v=%b retired=%0d, expected v=0 retired=1", bus.out_valid, bus.cnt_retired);
        end
    endtask

    task automatic test_rotw_scalar();
        logic [DW-1:0] a;
        logic [DW-1:0] want;
        logic          seen;
        apply_reset();
        a    = {32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h09CF_4F3C};
        want = {32'd0, 32'd0, 32'd0, 32'hCF4F_3C09};
        seen = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive_op(3'd6, 1'b0, a, {4{32'h1234_5678}}, 5'd9);
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (bus.out_result !== want || bus.out_vec !== 1'b0 || bus.out_rd !== 5'd9) begin
                    errors++;
                    $display("FAIL rotw_result: got %h vec=%b rd=%0d, expected %h vec=0 rd=9",
                             bus.out_result, bus.out_vec, bus.out_rd, want);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rotw_timeout: got no out_valid, expected one result");
        end
    endtask

    task automatic test_stall();
        logic [2:0]    ops[4];
        logic [DW-1:0] av[4];
        logic [DW-1:0] bv[4];
        int            issued;
        int            got;
        exp_t          e;
        apply_reset();
        ops = '{3'd0, 3'd1, 3'd2, 3'd5};
        for (int i = 0; i < 4; i++) begin
            av[i] = {$urandom, $urandom, $urandom, $urandom};
            bv[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        issued = 0;
        got    = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 8);
            if (issued < 4) drive_op(ops[issued], 1'b1, av[issued], bv[issued], 5'(issued + 1));
            else bus.in_valid = 1'b0;
            #1;
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (bus.out_valid !== (cyc == 3)) begin
                    errors++;
                    $display("FAIL stall_fill: cycle %0d out_valid got %b, expected %b", cyc, bus.out_valid, cyc == 3);
                end
            end
            if (cyc >= 3 && cyc < 8) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready: cycle %0d got %b, expected 0", cyc, bus.in_ready);
                end
            end
            if (cyc >= 3 && cyc <= 8) begin
                checks++;
                if (bus.cnt_stall !== 32'(cyc - 3)) begin
                    errors++;
                    $display("FAIL stall_count: cycle %0d got %0d, expected %0d", cyc, bus.cnt_stall, cyc - 3);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra: got rd=%0d, expected no output", bus.out_rd);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_result !== e.res || bus.out_rd !== e.rd) begin
                        errors++;
                        $display("FAIL stall_order: got rd=%0d res=%h, expected rd=%0d res=%h",
                                 bus.out_rd, bus.out_result, e.rd, e.res);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.res = ref_exec(ops[issued], 1'b1, av[issued], bv[issued]);
                e.rd  = 5'(issued + 1);
                e.vec = 1'b1;
                exp_q.push_back(e);
                issued++;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (got != 4 || exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: got %0d results (left %0d, v=%b), expected 4 (left 0, v=0)",
                     got, exp_q.size(), bus.out_valid);
        end
        checks++;
        if (bus.cnt_retired !== 32'd4 || bus.cnt_stall !== 32'd5) begin
            errors++;
            $display("FAIL stall_totals: got retired=%0d stall=%0d, expected 4/5", bus.cnt_retired, bus.cnt_stall);
        end
    endtask

    task automatic test_scoreboard();
        logic drained;
        apply_reset();
        @(negedge clk);
        drive_op(3'd7, 1'b1, '0, {4{32'h5}}, 5'd3);
        bus.q_vec = 1'b1;
        bus.q_rs1 = 5'd3;
        #1;
        checks++;
        if (bus.rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_offered: got rs1_busy=%b, expected 0", bus.rs1_busy);
        end
        @(negedge clk);
        drive_op(3'd7, 1'b0, '0, '0, 5'd0);
        #1;
        checks++;
        if (bus.rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL sb_vec_hit: got rs1_busy=%b, expected 1", bus.rs1_busy);
        end
        bus.q_vec = 1'b0;
        #1;
        checks++;
        if (bus.rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_class: got rs1_busy=%b, expected 0", bus.rs1_busy);
        end
        @(negedge clk);
        drive_op(3'd7, 1'b0, '0, '0, 5'd5);
        bus.q_rs2 = 5'd0;
        #1;
        checks++;
        if (bus.rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_zero: got rs2_busy=%b, expected 0", bus.rs2_busy);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.q_rs2    = 5'd5;
        #1;
        checks++;
        if (bus.rs2_busy !== 1'b1) begin
            errors++;
            $display("FAIL sb_scalar_hit: got rs2_busy=%b, expected 1", bus.rs2_busy);
        end
        drained = 1'b0;
        for (int c = 0; c < 12 && !drained; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            if (c > 0 && bus.out_valid === 1'b0) drained = 1'b1;
        end
        bus.q_vec = 1'b1;
        bus.q_rs1 = 5'd3;
        bus.q_vec = 1'b1;
        #1;
        checks++;
        if (!drained || bus.rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_retired_vec: got drained=%b rs1_busy=%b, expected 1/0", drained, bus.rs1_busy);
        end
        bus.q_vec = 1'b0;
        #1;
        checks++;
        if (bus.rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_retired_scalar: got rs2_busy=%b, expected 0", bus.rs2_busy);
        end
    endtask

    task automatic test_flush();
        logic ghost;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            drive_op(3'd0, 1'b1, {4{32'(i)}}, {4{32'd1}}, 5'(11 + i));
        end
        @(negedge clk);
        drive_op(3'd0, 1'b1, '0, '0, 5'd20);
        bus.flush = 1'b1;
        bus.q_vec = 1'b1;
        bus.q_rs1 = 5'd13;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle: got ready=%b v=%b busy=%b, expected 0/1/1",
                     bus.in_ready, bus.out_valid, bus.rs1_busy);
        end
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.rs1_busy !== 1'b0 || bus.cnt_retired !== 32'd1) begin
            errors++;
            $display("FAIL flush_kill: got v=%b busy=%b retired=%0d, expected 0/0/1",
                     bus.out_valid, bus.rs1_busy, bus.cnt_retired);
        end
        ghost = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid !== 1'b0) ghost = 1'b1;
        end
        checks++;
        if (ghost) begin
            errors++;
            $display("FAIL flush_ghost: got out_valid after flush, expected none");
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        @(negedge clk);
        drive_op(3'd4, 1'b1, {4{32'hF0}}, {4{32'h0F}}, 5'd4);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        bus.q_vec = 1'b1;
        bus.q_rs1 = 5'd4;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.rs1_busy !== 1'b1 || bus.cnt_stall === 32'd0) begin
            errors++;
            $display("FAIL arst_setup: got v=%b busy=%b stall=%0d, expected 1/1/nonzero",
                     bus.out_valid, bus.rs1_busy, bus.cnt_stall);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.rs1_busy !== 1'b0 || bus.out_result !== '0 ||
            bus.cnt_retired !== 32'd0 || bus.cnt_stall !== 32'd0) begin
            errors++;
            $display("FAIL arst_drop: got v=%b busy=%b res=%h ret=%0d stall=%0d, expected all zero",
                     bus.out_valid, bus.rs1_busy, bus.out_result, bus.cnt_retired, bus.cnt_stall);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n_ret;
        int   n_stall;
        logic exp_rdy;
        logic b1;
        logic b2;
        apply_reset();
        n_ret   = 0;
        n_stall = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            drive_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     {$urandom, $urandom, $urandom, $urandom},
                     {$urandom, $urandom, $urandom, $urandom}, 5'($urandom_range(0, 3)));
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 39) == 0);
            bus.q_vec     = 1'($urandom_range(0, 1));
            bus.q_rs1     = 5'($urandom_range(0, 3));
            bus.q_rs2     = 5'($urandom_range(0, 3));
            #1;
            exp_rdy = (!bus.out_valid || bus.out_ready) && !bus.flush;
            checks++;
            if (bus.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rnd_in_ready: cycle %0d got %b, expected %b", cyc, bus.in_ready, exp_rdy);
            end
            b1 = model_busy(bus.q_vec, bus.q_rs1);
            b2 = model_busy(bus.q_vec, bus.q_rs2);
            checks++;
            if (bus.rs1_busy !== b1 || bus.rs2_busy !== b2) begin
                errors++;
                $display("FAIL rnd_busy: cycle %0d got %b%b, expected %b%b", cyc, bus.rs1_busy, bus.rs2_busy, b1, b2);
            end
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_ghost: cycle %0d got out_valid with rd=%0d, expected none", cyc, bus.out_rd);
                end else if (bus.out_result !== exp_q[0].res || bus.out_rd !== exp_q[0].rd ||
                             bus.out_vec !== exp_q[0].vec) begin
                    errors++;
                    $display("FAIL rnd_result: cycle %0d got rd=%0d vec=%b res=%h, expected rd=%0d vec=%b res=%h",
                             cyc, bus.out_rd, bus.out_vec, bus.out_result,
                             exp_q[0].rd, exp_q[0].vec, exp_q[0].res);
                end
                if (bus.out_ready) begin
                    if (exp_q.size() != 0) e = exp_q.pop_front();
                    n_ret++;
                end else begin
                    n_stall++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.res = ref_exec(bus.in_op, bus.in_vec, bus.in_a, bus.in_b);
                e.rd  = bus.in_rd;
                e.vec = bus.in_vec;
                exp_q.push_back(e);
            end
            if (bus.flush) exp_q.delete();
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.cnt_retired !== 32'(n_ret) || bus.cnt_stall !== 32'(n_stall)) begin
            errors++;
            $display("FAIL rnd_counters: got retired=%0d stall=%0d, expected %0d/%0d",
                     bus.cnt_retired, bus.cnt_stall, n_ret, n_stall);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_add_vec();
        test_rotw_scalar();
        test_stall();
        test_scoreboard();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
